// File: rtl/core_result_arbiter.sv
// core_result_arbiter: collects per-core ray results through a round-robin
// grant, converts in-range pixel coordinates into linear frame-buffer
// addresses, queues them in a small write FIFO, and counts written pixels
// to signal the end of each frame.
// Optional feature: define ARBITER_STATS_EN to add stall_count_out, a
// saturating count of ACTIVE cycles in which a core was waiting but no
// grant was issued.
module core_result_arbiter #(
   parameter int NUM_CORES      = 4,
   parameter int DISPLAY_WIDTH  = 320,
   parameter int DISPLAY_HEIGHT = 180,
   parameter int H_BITS         = 9,
   parameter int V_BITS         = 8,
   parameter int COLOR_BITS     = 4,
   parameter int FIFO_DEPTH     = 4,
   localparam int ADDR_BITS     = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic                              frame_start_in,
   input  logic [NUM_CORES-1:0]              core_valid_in,
   input  logic [NUM_CORES*H_BITS-1:0]       core_hcount_in,
   input  logic [NUM_CORES*V_BITS-1:0]       core_vcount_in,
   input  logic [NUM_CORES*COLOR_BITS-1:0]   core_color_in,
   output logic [NUM_CORES-1:0]              core_ack_out,
   output logic                              wr_valid_out,
   input  logic                              wr_ready_in,
   output logic [ADDR_BITS-1:0]              wr_addr_out,
   output logic [COLOR_BITS-1:0]             wr_color_out,
   output logic                              frame_done_out,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_count_out
`ifdef ARBITER_STATS_EN
   ,
   output logic [31:0]                       stall_count_out
`endif
);

   localparam int PIXELS   = DISPLAY_WIDTH * DISPLAY_HEIGHT;
   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;
   localparam int IDX_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   localparam logic [CNT_BITS-1:0]  FULL_COUNT = CNT_BITS'(FIFO_DEPTH);
   localparam logic [ADDR_BITS-1:0] LAST_PIXEL = ADDR_BITS'(PIXELS - 1);
   localparam logic [IDX_BITS-1:0]  LAST_CORE  = IDX_BITS'(NUM_CORES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_DONE
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic                   grant_en;

   logic                   grant_any;
   logic [IDX_BITS-1:0]    grant_idx;
   logic [IDX_BITS-1:0]    last_grant;
   logic [NUM_CORES-1:0]   grant_vec;

   logic [H_BITS-1:0]      sel_h;
   logic [V_BITS-1:0]      sel_v;
   logic [COLOR_BITS-1:0]  sel_color;
   logic                   in_range;
   logic [ADDR_BITS-1:0]   push_addr;

   logic                   push;
   logic                   pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [ADDR_BITS-1:0]   mem_addr  [FIFO_DEPTH];
   logic [COLOR_BITS-1:0]  mem_color [FIFO_DEPTH];
   logic [PTR_BITS-1:0]    wr_ptr;
   logic [PTR_BITS-1:0]    rd_ptr;
   logic [CNT_BITS-1:0]    count;

   logic [ADDR_BITS-1:0]   pix_cnt;

   // Round-robin candidate: core (base + offset) mod NUM_CORES.
   function automatic logic [IDX_BITS-1:0] rr_index(input logic [IDX_BITS-1:0] base,
                                                    input int unsigned offset);
      int unsigned sum;
      sum = 32'(base) + offset;
      return IDX_BITS'(sum % NUM_CORES);
   endfunction

   // Frame state register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Frame state transitions; grants are only enabled while ACTIVE.
   // A frame_start arriving together with frame_done keeps the FSM ACTIVE.
   always_comb begin
      state_next = state;
      grant_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (frame_start_in) state_next = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            grant_en = 1'b1;
            if (!frame_start_in && frame_done_out) state_next = ST_DONE;
         end
         ST_DONE: begin
            if (frame_start_in) state_next = ST_ACTIVE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Round-robin search starting one past the last granted core. A full
   // FIFO blocks the grant even if it is being popped this cycle.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = last_grant;
      for (int unsigned k = 1; k <= NUM_CORES; k++) begin
         if (grant_en && !fifo_full && !grant_any &&
             core_valid_in[rr_index(last_grant, k)]) begin
            grant_any = 1'b1;
            grant_idx = rr_index(last_grant, k);
         end
      end
   end

   // One-hot grant vector from the selected index.
   always_comb begin
      grant_vec = '0;
      if (grant_any) grant_vec[grant_idx] = 1'b1;
   end

   assign core_ack_out = rst_in ? grant_vec : '0;

   // Granted core's result, range check and linear address.
   always_comb begin
      sel_h     = core_hcount_in[grant_idx*H_BITS +: H_BITS];
      sel_v     = core_vcount_in[grant_idx*V_BITS +: V_BITS];
      sel_color = core_color_in[grant_idx*COLOR_BITS +: COLOR_BITS];
      in_range  = (32'(sel_h) < DISPLAY_WIDTH) && (32'(sel_v) < DISPLAY_HEIGHT);
      push_addr = ADDR_BITS'(32'(sel_v) * DISPLAY_WIDTH + 32'(sel_h));
   end

   // Remember the most recent grant for the next round-robin search.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         last_grant <= LAST_CORE;
      end else if (grant_any) begin
         last_grant <= grant_idx;
      end
   end

   assign push       = grant_any && in_range;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_COUNT);
   assign pop        = !fifo_empty && wr_ready_in;

   assign wr_valid_out   = !fifo_empty;
   assign wr_addr_out    = mem_addr[rd_ptr];
   assign wr_color_out   = mem_color[rd_ptr];
   assign fifo_count_out = count;

   // FIFO storage; contents need no reset because occupancy gates validity.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem_addr[wr_ptr]  <= push_addr;
         mem_color[wr_ptr] <= sel_color;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_BITS'(1);
            2'b01:   count <= count - CNT_BITS'(1);
            default: count <= count;
         endcase
      end
   end

   // The last pixel of the frame is being written this cycle; a coincident
   // frame_start restarts the count, so that pop belongs to the new frame.
   assign frame_done_out = pop && !frame_start_in && (pix_cnt == LAST_PIXEL);

   // Written-pixel counter; frame_start restarts it, counting a same-cycle pop.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pix_cnt <= '0;
      end else if (frame_start_in) begin
         pix_cnt <= pop ? ADDR_BITS'(1) : '0;
      end else if (pop) begin
         pix_cnt <= (pix_cnt == LAST_PIXEL) ? '0 : pix_cnt + ADDR_BITS'(1);
      end
   end

`ifdef ARBITER_STATS_EN
   // Saturating count of ACTIVE cycles with a waiting core but no grant.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         stall_count_out <= '0;
      end else if (frame_start_in) begin
         stall_count_out <= '0;
      end else if (state == ST_ACTIVE && |core_valid_in && !grant_any &&
                   stall_count_out != '1) begin
         stall_count_out <= stall_count_out + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_core_result_arbiter.sv
// Bench for core_result_arbiter at a small 4x2 display so frame completion
// is reachable in a few cycles. A queue-based model checks every cycle;
// directed sequences add hand-computed expectations.
module tb_core_result_arbiter;

   localparam int NC  = 4;
   localparam int W   = 4;
   localparam int H   = 2;
   localparam int HB  = 4;
   localparam int VB  = 3;
   localparam int CB  = 4;
   localparam int DEP = 4;
   localparam int PIX = W * H;

   logic             clk;
   logic             rst;
   logic             frame_start;
   logic [NC-1:0]    core_valid;
   logic [NC*HB-1:0] core_h;
   logic [NC*VB-1:0] core_v;
   logic [NC*CB-1:0] core_c;
   logic [NC-1:0]    ack;
   logic             wr_valid;
   logic             wr_ready;
   logic [2:0]       wr_addr;
   logic [CB-1:0]    wr_color;
   logic             frame_done;
   logic [2:0]       fifo_count;

   int errors = 0;
   int checks = 0;

   core_result_arbiter #(
      .NUM_CORES(NC),
      .DISPLAY_WIDTH(W),
      .DISPLAY_HEIGHT(H),
      .H_BITS(HB),
      .V_BITS(VB),
      .COLOR_BITS(CB),
      .FIFO_DEPTH(DEP)
   ) dut (
      .clk_in(clk),
      .rst_in(rst),
      .frame_start_in(frame_start),
      .core_valid_in(core_valid),
      .core_hcount_in(core_h),
      .core_vcount_in(core_v),
      .core_color_in(core_c),
      .core_ack_out(ack),
      .wr_valid_out(wr_valid),
      .wr_ready_in(wr_ready),
      .wr_addr_out(wr_addr),
      .wr_color_out(wr_color),
      .frame_done_out(frame_done),
      .fifo_count_out(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_core(input int i, input int h, input int v, input int c);
      core_h[i*HB +: HB] = HB'(h);
      core_v[i*VB +: VB] = VB'(v);
      core_c[i*CB +: CB] = CB'(c);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: a queue of pending writes, the last granted core,
   // frame phase (0 idle, 1 active, 2 done) and pixels written this frame.
   int q_addr[$];
   int q_col[$];
   int m_last  = NC - 1;
   int m_state = 0;
   int m_pix   = 0;
   int e_grant, e_ack, e_pop, e_done, mh, mv, mc;

   always @(negedge clk) begin
      if (!rst) begin
         q_addr.delete();
         q_col.delete();
         m_last  = NC - 1;
         m_state = 0;
         m_pix   = 0;
         check("model_rst_ack", int'(ack), 0);
         check("model_rst_wr_valid", int'(wr_valid), 0);
         check("model_rst_count", int'(fifo_count), 0);
         check("model_rst_done", int'(frame_done), 0);
      end else begin
         e_grant = -1;
         if (m_state == 1 && q_addr.size() < DEP) begin
            for (int k = 1; k <= NC; k++) begin
               if (e_grant < 0 && core_valid[(m_last + k) % NC]) e_grant = (m_last + k) % NC;
            end
         end
         e_ack  = (e_grant >= 0) ? (1 << e_grant) : 0;
         e_pop  = (q_addr.size() > 0 && wr_ready) ? 1 : 0;
         e_done = (e_pop == 1 && !frame_start && m_pix == PIX - 1) ? 1 : 0;

         check("model_ack", int'(ack), e_ack);
         check("model_wr_valid", int'(wr_valid), (q_addr.size() > 0) ? 1 : 0);
         check("model_count", int'(fifo_count), q_addr.size());
         check("model_done", int'(frame_done), e_done);
         if (q_addr.size() > 0) begin
            check("model_wr_addr", int'(wr_addr), q_addr[0]);
            check("model_wr_color", int'(wr_color), q_col[0]);
         end

         if (e_pop == 1) begin
            void'(q_addr.pop_front());
            void'(q_col.pop_front());
         end
         if (e_grant >= 0) begin
            mh = int'(core_h[e_grant*HB +: HB]);
            mv = int'(core_v[e_grant*VB +: VB]);
            mc = int'(core_c[e_grant*CB +: CB]);
            m_last = e_grant;
            if (mh < W && mv < H) begin
               q_addr.push_back(mv * W + mh);
               q_col.push_back(mc);
            end
         end
         if (frame_start) m_pix = e_pop;
         else if (e_pop == 1) m_pix = (m_pix + 1) % PIX;
         if (frame_start) m_state = 1;
         else if (e_done == 1 && m_state == 1) m_state = 2;
      end
   end

   int dcount;

   initial begin
      rst = 1'b0;
      frame_start = 1'b0;
      core_valid = '0;
      core_h = '0;
      core_v = '0;
      core_c = '0;
      wr_ready = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset_ack", int'(ack), 0);
      check("reset_wr_valid", int'(wr_valid), 0);
      check("reset_count", int'(fifo_count), 0);
      check("reset_done", int'(frame_done), 0);
      cyc();
      rst = 1'b1;

      // IDLE never grants.
      core_valid = 4'hF;
      for (int i = 0; i < NC; i++) set_core(i, i, 0, i + 1);
      @(negedge clk);
      check("idle_no_grant", int'(ack), 0);
      cyc();
      core_valid = '0;

      // Round-robin with every core valid: 0,1,2,3,0.
      frame_start = 1'b1;
      @(negedge clk);
      cyc();
      frame_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         core_valid = 4'hF;
         @(negedge clk);
         check("rr_order", int'(ack), 1 << (k % 4));
         if (k == 1) begin
            check("rr_first_addr", int'(wr_addr), 0);
            check("rr_first_color", int'(wr_color), 1);
         end
         cyc();
      end
      core_valid = '0;
      repeat (3) begin
         @(negedge clk);
         cyc();
      end

      // Backpressure: four pushes fill the FIFO, then grants stop.
      frame_start = 1'b1;
      wr_ready = 1'b0;
      @(negedge clk);
      cyc();
      frame_start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         core_valid = 4'b0001;
         set_core(0, k % 4, 1, k);
         @(negedge clk);
         check("bp_ack", int'(ack), (k < 4) ? 1 : 0);
         if (k >= 4) check("bp_full_count", int'(fifo_count), 4);
         cyc();
      end
      wr_ready = 1'b1;
      set_core(0, 0, 0, 5);
      @(negedge clk);
      check("full_pop_no_grant", int'(ack), 0);
      check("full_pop_count", int'(fifo_count), 4);
      check("full_pop_head", int'(wr_addr), 4);
      cyc();
      @(negedge clk);
      check("after_pop_grant", int'(ack), 1);
      cyc();
      core_valid = '0;
      repeat (6) begin
         @(negedge clk);
         cyc();
      end

      // Out-of-range result is acked but not written; then addr 3+1*4=7.
      frame_start = 1'b1;
      @(negedge clk);
      cyc();
      frame_start = 1'b0;
      core_valid = 4'b0100;
      set_core(2, 5, 1, 3);
      @(negedge clk);
      check("oor_ack", int'(ack), 4);
      cyc();
      core_valid = 4'b0010;
      set_core(1, 3, 1, 9);
      @(negedge clk);
      check("oor_no_push_count", int'(fifo_count), 0);
      check("oor_no_push_valid", int'(wr_valid), 0);
      check("addr7_ack", int'(ack), 2);
      cyc();
      core_valid = '0;
      @(negedge clk);
      check("addr7_valid", int'(wr_valid), 1);
      check("addr7_addr", int'(wr_addr), 7);
      check("addr7_color", int'(wr_color), 9);
      cyc();
      repeat (2) begin
         @(negedge clk);
         cyc();
      end

      // Full frame of 8 pixels: done on the 8th pop, then no grants in DONE.
      frame_start = 1'b1;
      @(negedge clk);
      cyc();
      frame_start = 1'b0;
      dcount = 0;
      for (int k = 0; k < 11; k++) begin
         if (k < 8) begin
            core_valid = 4'b1000;
            set_core(3, k % 4, k / 4, k + 1);
         end else if (k == 8) begin
            core_valid = '0;
         end else begin
            core_valid = 4'b1000;
            set_core(3, 0, 0, 15);
         end
         @(negedge clk);
         if (frame_done) dcount++;
         if (k < 8) check("frame_grant", int'(ack), 8);
         if (k == 7) check("frame_not_done_yet", int'(frame_done), 0);
         if (k == 8) check("frame_done_8th_pop", int'(frame_done), 1);
         if (k >= 9) check("done_no_grant", int'(ack), 0);
         cyc();
      end
      check("frame_done_once", dcount, 1);
      core_valid = '0;

      // Reset mid-frame with three queued entries clears outputs at once.
      frame_start = 1'b1;
      wr_ready = 1'b0;
      @(negedge clk);
      cyc();
      frame_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         core_valid = 4'b0001;
         set_core(0, k, 0, k);
         @(negedge clk);
         cyc();
      end
      set_core(0, 3, 0, 3);
      #1;
      check("prereset_count", int'(fifo_count), 3);
      check("prereset_ack", int'(ack), 1);
      rst = 1'b0;
      #1;
      check("async_rst_valid", int'(wr_valid), 0);
      check("async_rst_count", int'(fifo_count), 0);
      check("async_rst_ack", int'(ack), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("post_reset_idle", int'(ack), 0);
      check("post_reset_empty", int'(wr_valid), 0);
      cyc();
      core_valid = '0;
      @(negedge clk);
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_result_arbiter.md
CORE_RESULT_ARBITER -- requirements
Module: core_result_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of ray units feeding results.
REQ-002 SHALL have parameter DISPLAY_WIDTH, default 320: pixels per row.
REQ-003 SHALL have parameter DISPLAY_HEIGHT, default 180: rows per frame.
REQ-004 SHALL have parameters H_BITS/V_BITS, default 9/8, and COLOR_BITS, default 4: coordinate and color widths.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4 (power of two): depth of the write FIFO.
REQ-006 SHALL derive ADDR_BITS = clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT).
REQ-007 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-008 rst_in  input  1  asynchronous, active-low reset.
REQ-009 frame_start_in  input  1  one-cycle pulse; a new frame begins.
REQ-010 core_valid_in  input  NUM_CORES  per-core result-available flag.
REQ-011 core_hcount_in / core_vcount_in / core_color_in  input  NUM_CORES x H_BITS / V_BITS / COLOR_BITS  per-core result.
REQ-012 core_ack_out  output  NUM_CORES  one-hot grant; the core drops valid on the next cycle.
REQ-013 wr_valid_out / wr_ready_in  output / input  1  frame-buffer write handshake.
REQ-014 wr_addr_out / wr_color_out  output  ADDR_BITS / COLOR_BITS  write address and data.
REQ-015 frame_done_out  output  1  one-cycle pulse when all pixels of the frame have been written.
REQ-016 fifo_count_out  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL implement FSM IDLE -> ACTIVE on frame_start_in; ACTIVE -> DONE on frame_done_out; DONE -> ACTIVE on frame_start_in.
REQ-018 SHALL grant only in ACTIVE when the FIFO is not full, with at most one grant per cycle; core_ack_out is combinational from the grant.
REQ-019 SHALL arbitrate round-robin: the search starts at index last_grant+1 mod NUM_CORES; last_grant resets to NUM_CORES-1, so core 0 has first priority.
REQ-020 SHALL treat a full FIFO with a pop in the same cycle as full, so no grant occurs that cycle.
REQ-021 On a grant with hcount<DISPLAY_WIDTH and vcount<DISPLAY_HEIGHT, SHALL push {vcount*DISPLAY_WIDTH+hcount, color} into the FIFO in the same cycle.
REQ-022 On a grant with out-of-range coordinates, SHALL ack the core but push nothing.
REQ-023 SHALL present the FIFO head on wr_addr_out/wr_color_out with wr_valid_out = not empty; a pop occurs when wr_valid_out && wr_ready_in.
REQ-024 Push-to-wr_valid_out latency SHALL be 1 cycle when the FIFO is empty.
REQ-025 Simultaneous push and pop SHALL leave the count unchanged.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 The pixel counter SHALL increment per pop; reaching DISPLAY_WIDTH*DISPLAY_HEIGHT SHALL pulse frame_done_out for one cycle and wrap the counter to 0.
REQ-028 frame_start_in SHALL clear the pixel counter, loading 1 if a pop occurs in the same cycle.
REQ-029 frame_start_in SHALL NOT flush the FIFO.
REQ-030 frame_start_in while ACTIVE SHALL restart counting and keep the FSM in ACTIVE.
REQ-031 In IDLE and DONE, the block SHALL keep draining the FIFO and SHALL NOT grant.

Reset
REQ-032 On rst_in low, SHALL asynchronously set FSM=IDLE, FIFO empty, pixel counter 0, last_grant NUM_CORES-1, frame_done_out 0, wr_valid_out 0, fifo_count_out 0.
REQ-033 Reset mid-frame SHALL discard FIFO contents.
REQ-034 core_ack_out SHALL be 0 while rst_in is low.

Configuration
REQ-035 With ARBITER_STATS_EN defined, SHALL add output stall_count_out (32 bits), counting cycles in ACTIVE where some core_valid_in is set and no grant occurs; it is cleared by reset and frame_start_in and saturates at all-ones.
REQ-036 Without ARBITER_STATS_EN, the port and counter SHALL be absent.

Verification
REQ-037 Reset, frame_start, all 4 cores valid continuously, wr_ready_in=1 -> acks in order 0,1,2,3,0 on consecutive cycles.
REQ-038 wr_ready_in=0, core 0 valid with new data each cycle -> 4 pushes, fifo_count_out=4, then no ack until wr_ready_in=1.
REQ-039 W=4,H=2, 8 in-range results -> frame_done_out pulses once, on the cycle of the 8th pop; FSM in DONE; a 9th valid is not acked.
REQ-040 Result hcount=5,vcount=1 at W=4 -> acked, fifo_count_out unchanged, no write.
REQ-041 Result hcount=3,vcount=1 at W=4 -> wr_addr_out=7 one cycle after the grant.
REQ-042 rst_in low mid-frame with FIFO holding 3 entries -> wr_valid_out=0 and fifo_count_out=0 immediately, without waiting for a clock edge.
